seq_bit_serializer: RTL and testbench
=====================================

Name: seq_bit_serializer

Overview:
Parallel-to-serial stage that sits directly upstream of the 1011 sequence detector and drives its inp_bit input. It accepts DATA_W-bit words over a valid/ready handshake and emits one bit per clock. A one-word holding register gives gap-free streaming across word boundaries. Framing strobes (ser_valid, word_done, underrun) are provided for the testbench and for the downstream match-accounting logic.

Parameters:
DATA_W, 8, word width in bits (>= 2)
MSB_FIRST, 1, 1: bit DATA_W-1 is sent first; 0: bit 0 is sent first
IDLE_BIT, 0, value driven on ser_bit while no word is shifting

Ports:
clk  input  1  clock, rising-edge
reset  input  1  reset, synchronous, active-high
in_data  input  DATA_W  parallel word to serialize
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word this cycle
ser_bit  output  1  serial bit, connects to detector inp_bit
ser_valid  output  1  ser_bit carries payload this cycle
word_done  output  1  high in the cycle the last bit of a word is presented
underrun  output  1  one-cycle pulse: stream stopped after a word because no next word was queued

Behaviour:
- Clock, reset: clock clk; reset reset, synchronous, active-high.
- State: shift register shreg[DATA_W], bit counter cnt (clog2(DATA_W) bits), active flag, hold register hold[DATA_W], hold_v flag, underrun_q.
- Reset values: active=0, hold_v=0, shreg=0, cnt=0, underrun_q=0. Outputs during and after reset: ser_bit=IDLE_BIT, ser_valid=0, in_ready=1, word_done=0, underrun=0.
- Reset mid-word aborts the word. The partial word and any held word are discarded; no remaining bits are emitted.
- Output equations (all driven from registers only):
  - in_ready = !hold_v
  - ser_valid = active
  - ser_bit = active ? (MSB_FIRST ? shreg[DATA_W-1] : shreg[0]) : IDLE_BIT
  - word_done = active && cnt==DATA_W-1
  - underrun = underrun_q
- Handshake: a word is accepted on a rising edge where in_valid && in_ready. in_data is sampled only on acceptance. in_valid may drop at any time without a transfer.
- FSM (states IDLE = !active, SHIFT = active); per rising edge:
  - IDLE, accept: shreg<=in_data, cnt<=0, active<=1. First bit appears in the cycle immediately after the accepting edge (latency 1). hold is untouched.
  - SHIFT, not last bit: shift shreg by one toward the output end (left if MSB_FIRST, else right); cnt<=cnt+1. An accept in this cycle writes hold, hold_v<=1.
  - SHIFT, last bit, hold_v=1: shreg<=hold, cnt<=0, hold_v<=0, active stays 1. No bubble. in_ready is low this cycle, so no simultaneous accept.
  - SHIFT, last bit, hold_v=0, accept: shreg<=in_data directly, cnt<=0, active stays 1. No bubble.
  - SHIFT, last bit, hold_v=0, no accept: active<=0, underrun_q<=1 for exactly one cycle.
- underrun_q clears on the following edge unless it is set again.
- Sustained throughput: one word per DATA_W cycles when the source keeps in_valid high; ser_valid stays continuously high.
- Bits shifted in behind the output end are 0. They are never observable while active.

Test Plan:
- Single word: DATA_W=8, MSB_FIRST=1, accept 8'hB0 at edge k -> ser_bit = 1,0,1,1,0,0,0,0 in cycles k+1..k+8; ser_valid high for those 8 cycles; word_done high at k+8; underrun pulse at k+9; detector seq_seen high once, one cycle after the 4th bit.
- Back-to-back: in_valid held with 8'h5A then 8'hC3 -> 16 contiguous ser_valid cycles with bits 01011010 11000011; in_ready low while the second word sits in hold; no underrun until after bit 16.
- Bit order: MSB_FIRST=0, word 8'h0D -> ser_bit = 1,0,1,1,0,0,0,0; word_done on the 8th bit.
- Accept exactly on the last-bit cycle with hold empty: second word follows with no bubble; hold_v stays 0; no underrun.
- Reset mid-word: assert reset after the 3rd bit of 8'hFF -> next cycle ser_valid=0, ser_bit=IDLE_BIT, in_ready=1; a queued hold word is never emitted.
- Idle stability: no in_valid for 20 cycles after reset -> ser_bit constant IDLE_BIT, ser_valid=0, word_done=0, underrun=0.

Source files
------------

// File: rtl/seq_bit_serializer_if.sv
// Word-in / bit-out bus between a word source and the bit serializer that feeds
// the 1011 detector.
interface seq_bit_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ser_bit;
  logic              ser_valid;
  logic              word_done;
  logic              underrun;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_bit, ser_valid, word_done, underrun
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_bit, ser_valid, word_done, underrun
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial stage: takes DATA_W-bit words over valid/ready and emits
// one bit per clock, with a one-word holding register for gap-free streaming.
module seq_bit_serializer #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input logic                clk,
  input logic                reset,
  seq_bit_serializer_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] hold;
  logic [CNT_W-1:0]  cnt;
  logic              hold_v;
  logic              underrun_q;

  logic              active;
  logic              accept;
  logic [DATA_W-1:0] shreg_next;

  assign active = (state == SHIFT);
  assign accept = bus.in_valid && !hold_v;

  // Zeros fill in behind the output end; they never reach ser_bit while active.
  assign shreg_next = MSB_FIRST ? {shreg[DATA_W-2:0], 1'b0}
                                : {1'b0, shreg[DATA_W-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      hold       <= '0;
      cnt        <= '0;
      hold_v     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= bus.in_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != LAST_CNT) begin
            shreg <= shreg_next;
            cnt   <= cnt + 1'b1;
            if (accept) begin
              hold   <= bus.in_data;
              hold_v <= 1'b1;
            end
          end else if (hold_v) begin
            // in_ready is low here, so no accept can collide with the reload.
            shreg  <= hold;
            cnt    <= '0;
            hold_v <= 1'b0;
          end else if (accept) begin
            shreg <= bus.in_data;
            cnt   <= '0;
          end else begin
            state      <= IDLE;
            underrun_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !hold_v;
  assign bus.ser_valid = active;
  assign bus.ser_bit   = active ? (MSB_FIRST ? shreg[DATA_W-1] : shreg[0]) : IDLE_BIT;
  assign bus.word_done = active && (cnt == LAST_CNT);
  assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: an MSB-first instance driven from a
// vector table, plus an LSB-first instance and reset/idle sequences.
module tb_seq_bit_serializer;

  logic clk;
  logic reset;

  seq_bit_serializer_if #(.DATA_W(8)) bus_msb ();
  seq_bit_serializer_if #(.DATA_W(8)) bus_lsb ();

  seq_bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_msb.slave)
  );

  seq_bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_lsb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {ser_bit, ser_valid, in_ready, word_done, underrun}.
  logic [4:0] obs_msb;
  logic [4:0] obs_lsb;
  assign obs_msb = {bus_msb.ser_bit, bus_msb.ser_valid, bus_msb.in_ready,
                    bus_msb.word_done, bus_msb.underrun};
  assign obs_lsb = {bus_lsb.ser_bit, bus_lsb.ser_valid, bus_lsb.in_ready,
                    bus_lsb.word_done, bus_lsb.underrun};

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic addVec(input logic v, input logic [7:0] d, input logic [4:0] e);
    vec_t t;
    t.valid = v;
    t.data  = d;
    t.exp   = e;
    vecs.push_back(t);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    bus_msb.in_valid = v;
    bus_msb.in_data  = d;
  endtask

  task automatic checkOutput(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: bit/valid/ready/done/underrun got %b required %b at %0t",
               name, act, exp, $time);
    end
  endtask

  initial begin
    logic exp_lsb_seq [8];
    exp_lsb_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    reset            = 1'b1;
    bus_msb.in_valid = 1'b0;
    bus_msb.in_data  = '0;
    bus_lsb.in_valid = 1'b0;
    bus_lsb.in_data  = '0;

    // Single word 8'hB0
    addVec(1'b1, 8'hB0, 5'b00100);
    addVec(1'b0, 8'h00, 5'b11100);
    addVec(1'b0, 8'h00, 5'b01100);
    addVec(1'b0, 8'h00, 5'b11100);
    addVec(1'b0, 8'h00, 5'b11100);
    addVec(1'b0, 8'h00, 5'b01100);
    addVec(1'b0, 8'h00, 5'b01100);
    addVec(1'b0, 8'h00, 5'b01100);
    addVec(1'b0, 8'h00, 5'b01110);
    addVec(1'b0, 8'h00, 5'b00101);
    addVec(1'b0, 8'h00, 5'b00100);
    // Back-to-back 8'h5A then 8'hC3; C3 waits in hold with in_ready low
    addVec(1'b1, 8'h5A, 5'b00100);
    addVec(1'b1, 8'hC3, 5'b01100);
    addVec(1'b0, 8'h00, 5'b11000);
    addVec(1'b0, 8'h00, 5'b01000);
    addVec(1'b0, 8'h00, 5'b11000);
    addVec(1'b0, 8'h00, 5'b11000);
    addVec(1'b0, 8'h00, 5'b01000);
    addVec(1'b0, 8'h00, 5'b11000);
    addVec(1'b0, 8'h00, 5'b01010);
    addVec(1'b0, 8'h00, 5'b11100);
    addVec(1'b0, 8'h00, 5'b11100);
    addVec(1'b0, 8'h00, 5'b01100);
    addVec(1'b0, 8'h00, 5'b01100);
    addVec(1'b0, 8'h00, 5'b01100);
    addVec(1'b0, 8'h00, 5'b01100);
    addVec(1'b0, 8'h00, 5'b11100);
    addVec(1'b0, 8'h00, 5'b11110);
    addVec(1'b0, 8'h00, 5'b00101);
    // 8'h81, then 8'h96 accepted exactly on the last-bit cycle with hold empty
    addVec(1'b1, 8'h81, 5'b00100);
    addVec(1'b0, 8'h00, 5'b11100);
    addVec(1'b0, 8'h00, 5'b01100);
    addVec(1'b0, 8'h00, 5'b01100);
    addVec(1'b0, 8'h00, 5'b01100);
    addVec(1'b0, 8'h00, 5'b01100);
    addVec(1'b0, 8'h00, 5'b01100);
    addVec(1'b0, 8'h00, 5'b01100);
    addVec(1'b1, 8'h96, 5'b11110);
    addVec(1'b0, 8'h00, 5'b11100);
    addVec(1'b0, 8'h00, 5'b01100);
    addVec(1'b0, 8'h00, 5'b01100);
    addVec(1'b0, 8'h00, 5'b11100);
    addVec(1'b0, 8'h00, 5'b01100);
    addVec(1'b0, 8'h00, 5'b11100);
    addVec(1'b0, 8'h00, 5'b11100);
    addVec(1'b0, 8'h00, 5'b01110);
    addVec(1'b0, 8'h00, 5'b00101);
    addVec(1'b0, 8'h00, 5'b00100);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_msb", obs_msb, 5'b00100);
    checkOutput("reset_lsb", obs_lsb, 5'b00100);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle", obs_msb, 5'b00100);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), obs_msb, vecs[i].exp);
      applyStimulus(vecs[i].valid, vecs[i].data);
    end

    // LSB-first instance, word 8'h0D
    @(negedge clk);
    bus_lsb.in_valid = 1'b1;
    bus_lsb.in_data  = 8'h0D;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus_lsb.in_valid = 1'b0;
      checkOutput($sformatf("lsb_bit%0d", i), obs_lsb,
                  {exp_lsb_seq[i], 1'b1, 1'b1, (i == 7), 1'b0});
    end
    @(negedge clk);
    checkOutput("lsb_underrun", obs_lsb, 5'b00101);

    // Reset after the 3rd bit of 8'hFF with 8'hAA sitting in hold
    @(negedge clk);
    checkOutput("rst_pre", obs_msb, 5'b00100);
    applyStimulus(1'b1, 8'hFF);
    @(negedge clk);
    checkOutput("rst_bit1", obs_msb, 5'b11100);
    applyStimulus(1'b1, 8'hAA);
    @(negedge clk);
    checkOutput("rst_bit2", obs_msb, 5'b11000);
    applyStimulus(1'b0, 8'h00);
    @(negedge clk);
    checkOutput("rst_bit3", obs_msb, 5'b11000);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_abort", obs_msb, 5'b00100);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("rst_quiet", obs_msb, 5'b00100);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
